// File: rtl/ud_direction_ctrl.sv
// Direction controller for a 3-bit up/down counter: drives the counter's ud input
// from a fixed mode, a bounce between limits, or a debounced pushbutton toggle.
module ud_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TURN_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        data,
  input  logic [1:0]        mode,
  input  logic [2:0]        lo,
  input  logic [2:0]        hi,
  input  logic              btn_raw,
  output logic              ud,
  output logic              dir_change,
  output logic              btn_pulse,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BUTTON = 2'b11
  } mode_e;

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TURN_W-1:0] TURN_MAX = '1;

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  dbc_q, dbc_d;
  logic              btn_pulse_q, btn_pulse_d;
  logic              ud_q, ud_d;
  logic              dir_change_q, dir_change_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic [2:0]        nxt;

  // Debounce: level only follows the synchronized input after it has differed
  // from it for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    level_d = level_q;
    dbc_d   = '0;
    if (sync2_q != level_q) begin
      if (dbc_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
    btn_pulse_d = level_d & ~level_q;
  end

  // nxt is the value the counter takes on this edge, so turning on it stops
  // the counter exactly at the limit instead of one step past it.
  assign nxt = ud_q ? (data - 3'd1) : (data + 3'd1);

  always_comb begin
    ud_d      = ud_q;
    cfg_err_d = 1'b0;
    case (mode_e'(mode))
      MODE_UP:     ud_d = 1'b0;
      MODE_DOWN:   ud_d = 1'b1;
      MODE_BUTTON: if (btn_pulse_q) ud_d = ~ud_q;
      MODE_BOUNCE: begin
        if (lo >= hi) begin
          cfg_err_d = 1'b1;
          ud_d      = 1'b0;
        end else if (nxt >= hi) begin
          ud_d = 1'b1;
        end else if (nxt <= lo) begin
          ud_d = 1'b0;
        end
      end
      default:     ud_d = ud_q;
    endcase
    dir_change_d = (ud_d != ud_q);
    turn_cnt_d   = turn_cnt_q;
    if (dir_change_d && (turn_cnt_q != TURN_MAX)) turn_cnt_d = turn_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      dbc_q        <= '0;
      btn_pulse_q  <= 1'b0;
      ud_q         <= 1'b0;
      dir_change_q <= 1'b0;
      turn_cnt_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      dbc_q        <= dbc_d;
      btn_pulse_q  <= btn_pulse_d;
      ud_q         <= ud_d;
      dir_change_q <= dir_change_d;
      turn_cnt_q   <= turn_cnt_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign ud         = ud_q;
  assign dir_change = dir_change_q;
  assign btn_pulse  = btn_pulse_q;
  assign turn_cnt   = turn_cnt_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_ud_direction_ctrl.sv
// Table-driven bench for ud_direction_ctrl (DEBOUNCE_CYCLES=4, TURN_W=2) with
// hand-written sequences for debounce timing and mode/button collisions.
module tb_ud_direction_ctrl;

  localparam logic [1:0] MUP = 2'b00;
  localparam logic [1:0] MDN = 2'b01;
  localparam logic [1:0] MBN = 2'b10;
  localparam logic [1:0] MBT = 2'b11;

  logic       clk;
  logic       reset;
  logic [2:0] data;
  logic [1:0] mode;
  logic [2:0] lo;
  logic [2:0] hi;
  logic       btn_raw;
  logic       ud;
  logic       dir_change;
  logic       btn_pulse;
  logic [1:0] turn_cnt;
  logic       cfg_err;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [2:0] data;
    logic       btn;
    logic       e_ud;
    logic       e_dc;
    logic       e_bp;
    logic [1:0] e_tc;
    logic       e_ce;
    string      tag;
  } vec_t;

  vec_t vec_q[$];

  ud_direction_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TURN_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data(data),
    .mode(mode),
    .lo(lo),
    .hi(hi),
    .btn_raw(btn_raw),
    .ud(ud),
    .dir_change(dir_change),
    .btn_pulse(btn_pulse),
    .turn_cnt(turn_cnt),
    .cfg_err(cfg_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic drive(input logic r, input logic [1:0] m, input logic [2:0] l,
                       input logic [2:0] h, input logic [2:0] d, input logic b);
    reset   = r;
    mode    = m;
    lo      = l;
    hi      = h;
    data    = d;
    btn_raw = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic e_ud, input logic e_dc,
                       input logic e_bp, input logic [1:0] e_tc, input logic e_ce);
    n_vec++;
    if (ud !== e_ud || dir_change !== e_dc || btn_pulse !== e_bp ||
        turn_cnt !== e_tc || cfg_err !== e_ce) begin
      n_miss++;
      $display("FAIL %s: got ud=%0b dc=%0b bp=%0b tc=%0d ce=%0b, expected ud=%0b dc=%0b bp=%0b tc=%0d ce=%0b",
               tag, ud, dir_change, btn_pulse, turn_cnt, cfg_err,
               e_ud, e_dc, e_bp, e_tc, e_ce);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] m, input logic [2:0] l,
                              input logic [2:0] h, input logic [2:0] d, input logic b,
                              input logic e_ud, input logic e_dc, input logic e_bp,
                              input logic [1:0] e_tc, input logic e_ce, input string tag);
    vec_t v;
    v.rst = r; v.mode = m; v.lo = l; v.hi = h; v.data = d; v.btn = b;
    v.e_ud = e_ud; v.e_dc = e_dc; v.e_bp = e_bp; v.e_tc = e_tc; v.e_ce = e_ce;
    v.tag = tag;
    vec_q.push_back(v);
  endfunction

  // Cycles from btn_raw going high until btn_pulse shows, bounded.
  task automatic wait_pulse(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_pulse === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    logic [2:0] bounce_d[14];
    logic       bounce_ud[14];
    logic       bounce_dc[14];
    logic [1:0] bounce_tc[14];

    drive(1'b1, MBN, 3'd2, 3'd5, 3'd4, 1'b1);

    // 1: reset dominates a bounce turn and a held button; debounce starts clean after
    for (int i = 0; i < 3; i++) add(1, MBN, 2, 5, 4, 1, 0, 0, 0, 0, 0, "t1_reset");
    for (int i = 0; i < 5; i++) add(0, MBT, 2, 5, 4, 1, 0, 0, 0, 0, 0, "t1_debounce");
    add(0, MBT, 2, 5, 4, 1, 0, 0, 1, 0, 0, "t1_pulse_edge6");
    add(0, MBT, 2, 5, 4, 1, 1, 1, 0, 1, 0, "t1_toggle");

    // 2: bounce lo=2 hi=5, closed-loop counter values precomputed
    bounce_d  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3};
    bounce_ud = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bounce_dc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bounce_tc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    add(1, MBN, 2, 5, 0, 0, 0, 0, 0, 0, 0, "t2_reset");
    for (int i = 0; i < 14; i++)
      add(0, MBN, 2, 5, bounce_d[i], 0, bounce_ud[i], bounce_dc[i], 0, bounce_tc[i], 0, "t2_bounce");

    // 3: lo>=hi flags a config error and free-runs up
    add(1, MBN, 5, 5, 0, 0, 0, 0, 0, 0, 0, "t3_reset");
    for (int i = 0; i < 9; i++) add(0, MBN, 5, 5, 3'(i), 0, 0, 0, 0, 0, 1, "t3_cfg_err");
    add(0, MUP, 5, 5, 1, 0, 0, 0, 0, 0, 0, "t3_cfg_clear");

    // 4: 3-cycle glitch ignored, then a held press toggles ud
    add(1, MBT, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_reset");
    for (int i = 0; i < 3; i++) add(0, MBT, 0, 0, 0, 1, 0, 0, 0, 0, 0, "t4_glitch_hi");
    for (int i = 0; i < 5; i++) add(0, MBT, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_glitch_lo");
    for (int i = 0; i < 5; i++) add(0, MBT, 0, 0, 0, 1, 0, 0, 0, 0, 0, "t4_hold");
    add(0, MBT, 0, 0, 0, 1, 0, 0, 1, 0, 0, "t4_pulse");
    add(0, MBT, 0, 0, 0, 1, 1, 1, 0, 1, 0, "t4_toggle");
    add(0, MBT, 0, 0, 0, 1, 1, 0, 0, 1, 0, "t4_hold_after");

    // 5: UP/DOWN toggling saturates turn_cnt at 3
    add(1, MUP, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t5_reset");
    add(0, MDN, 0, 0, 0, 0, 1, 1, 0, 1, 0, "t5_turn1");
    add(0, MUP, 0, 0, 0, 0, 0, 1, 0, 2, 0, "t5_turn2");
    add(0, MDN, 0, 0, 0, 0, 1, 1, 0, 3, 0, "t5_turn3");
    add(0, MUP, 0, 0, 0, 0, 0, 1, 0, 3, 0, "t5_turn4_sat");
    add(0, MDN, 0, 0, 0, 0, 1, 1, 0, 3, 0, "t5_turn5_sat");
    add(0, MDN, 0, 0, 0, 0, 1, 0, 0, 3, 0, "t5_steady");

    foreach (vec_q[i]) begin
      drive(vec_q[i].rst, vec_q[i].mode, vec_q[i].lo, vec_q[i].hi, vec_q[i].data, vec_q[i].btn);
      step();
      check($sformatf("%s[%0d]", vec_q[i].tag, i), vec_q[i].e_ud, vec_q[i].e_dc,
            vec_q[i].e_bp, vec_q[i].e_tc, vec_q[i].e_ce);
    end

    // 6a: press completes while mode switches BUTTON->UP; ud must stay 0
    drive(1, MBT, 0, 0, 0, 0);
    step();
    check("s6_reset", 0, 0, 0, 0, 0);
    drive(0, MBT, 0, 0, 0, 1);
    wait_pulse(cyc);
    check_int("s6_pulse_latency", cyc, 6);
    mode = MUP;
    step();
    check("s6_mode_up_wins", 0, 0, 0, 0, 0);

    // 6b: release produces no pulse, then a press completing with mode=DOWN
    drive(0, MBT, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("s6_release", 0, 0, 0, 0, 0);
    end
    btn_raw = 1'b1;
    wait_pulse(cyc);
    check_int("s6_pulse_latency2", cyc, 6);
    mode = MDN;
    step();
    check("s6_mode_down_wins", 1, 1, 0, 1, 0);
    mode = MBT;
    step();
    check("s6_button_hold", 1, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
